// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-cache request/response, downstream
// stall and redirect controls, and the {inst, inst_hit, inst_pc, inst_pc4}
// decode-side outputs plus sticky error flags.
//   master : the fetch unit (drives imem_req/imem_addr and decode outputs)
//   slave  : the environment (cache, decode stage, branch resolution)
interface inst_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_hit;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic        inst_hit;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        timeout_err;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr, inst, inst_hit, inst_pc, inst_pc4,
               timeout_err, misalign_err,
        input  imem_hit, imem_rdata, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_hit, inst_pc, inst_pc4,
               timeout_err, misalign_err,
        output imem_hit, imem_rdata, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage. Owns the PC, requests words from the instruction
// cache and presents {inst, inst_hit, inst_pc, inst_pc4} to decode.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - inst_fetch_unit_if.master: imem_req/imem_addr out, imem_hit/
//          imem_rdata in, stall/redirect_valid/redirect_pc in, decode
//          outputs and sticky timeout_err/misalign_err out.
// Priority per edge: rst > redirect_valid > stall > hit/miss.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned MISS_TIMEOUT = 16,
    parameter logic [31:0] NOP          = 32'h0000_0013
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_unit_if.master bus
);
    localparam int unsigned    CW       = $clog2(MISS_TIMEOUT + 1);
    localparam logic [CW-1:0] MISS_MAX = CW'(MISS_TIMEOUT);

    typedef enum logic {
        FETCH,
        MISS
    } state_t;

    state_t        state, state_n;
    logic [31:0]   pc, pc_n;
    logic [31:0]   inst, inst_n;
    logic          inst_hit, inst_hit_n;
    logic [31:0]   inst_pc, inst_pc_n;
    logic [31:0]   inst_pc4, inst_pc4_n;
    logic [CW-1:0] miss_cnt, miss_cnt_n;
    logic          tout, tout_n;
    logic          misal, misal_n;
    logic          run;
    logic          req;

    // run holds off the first request until one edge after reset release
    assign req = run & ~bus.stall & ~bus.redirect_valid;

    assign bus.imem_req     = req;
    assign bus.imem_addr    = pc;
    assign bus.inst         = inst;
    assign bus.inst_hit     = inst_hit;
    assign bus.inst_pc      = inst_pc;
    assign bus.inst_pc4     = inst_pc4;
    assign bus.timeout_err  = tout;
    assign bus.misalign_err = misal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            inst     <= NOP;
            inst_hit <= 1'b0;
            inst_pc  <= RESET_PC;
            inst_pc4 <= RESET_PC + 32'd4;
            miss_cnt <= '0;
            tout     <= 1'b0;
            misal    <= 1'b0;
            run      <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            inst     <= inst_n;
            inst_hit <= inst_hit_n;
            inst_pc  <= inst_pc_n;
            inst_pc4 <= inst_pc4_n;
            miss_cnt <= miss_cnt_n;
            tout     <= tout_n;
            misal    <= misal_n;
            run      <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        inst_n     = inst;
        inst_hit_n = inst_hit;
        inst_pc_n  = inst_pc;
        inst_pc4_n = inst_pc4;
        miss_cnt_n = miss_cnt;
        tout_n     = tout;
        misal_n    = misal;

        if (bus.redirect_valid) begin
            // Redirect flushes the presented word and abandons any miss
            pc_n       = {bus.redirect_pc[31:2], 2'b00};
            inst_n     = NOP;
            inst_hit_n = 1'b0;
            state_n    = FETCH;
            miss_cnt_n = '0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                misal_n = 1'b1;
            end
        end else if (bus.stall) begin
            // everything holds; imem_hit is ignored
        end else if (req) begin
            if (bus.imem_hit) begin
                inst_n     = bus.imem_rdata;
                inst_hit_n = 1'b1;
                inst_pc_n  = pc;
                inst_pc4_n = pc + 32'd4;
                pc_n       = pc + 32'd4;
                state_n    = FETCH;
                miss_cnt_n = '0;
            end else begin
                inst_n     = NOP;
                inst_hit_n = 1'b0;
                state_n    = MISS;
                miss_cnt_n = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 1'b1;
                if (miss_cnt_n == MISS_MAX) begin
                    tout_n = 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit. A reference PC/flag model tracks
// expected state; each accepted hit pushes {inst, pc, pc4} to a scoreboard
// that is popped when the DUT presents the word.
module tb_inst_fetch_unit;
    localparam logic [31:0] RPC = 32'hFFFF_FFFC;
    localparam int unsigned MT  = 4;
    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] rmask;

    inst_fetch_unit_if ifc ();

    inst_fetch_unit #(
        .RESET_PC     (RPC),
        .MISS_TIMEOUT (MT),
        .NOP          (NOPW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // cache model: returned word is a function of the address
    assign ifc.imem_rdata = ifc.imem_addr ^ rmask;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [95:0] sb[$];
    logic [95:0] last_word;
    logic [31:0] pc_e;
    logic        run_e, hit_e, tout_e, mis_e;
    int unsigned miss_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic model_reset();
        pc_e = RPC; run_e = 1'b0; hit_e = 1'b0; tout_e = 1'b0; mis_e = 1'b0;
        miss_e = 0; sb.delete(); last_word = {NOPW, RPC, RPC + 32'd4};
    endtask

    task automatic check_reset_vals();
        check("rst_inst_hit", {31'd0, ifc.inst_hit}, 32'd0);
        check("rst_inst", ifc.inst, NOPW);
        check("rst_inst_pc", ifc.inst_pc, RPC);
        check("rst_inst_pc4", ifc.inst_pc4, RPC + 32'd4);
        check("rst_addr", ifc.imem_addr, RPC);
        check("rst_req", {31'd0, ifc.imem_req}, 32'd0);
        check("rst_tout", {31'd0, ifc.timeout_err}, 32'd0);
        check("rst_misal", {31'd0, ifc.misalign_err}, 32'd0);
    endtask

    // One cycle: drive inputs, check request side, advance model, clock,
    // then check decode-side outputs.
    task automatic cyc(input logic h, input logic s, input logic rv, input logic [31:0] rpc);
        logic req_e;
        logic fresh;
        logic [95:0] w;
        ifc.imem_hit = h; ifc.stall = s; ifc.redirect_valid = rv; ifc.redirect_pc = rpc;
        #1;
        req_e = run_e & ~s & ~rv;
        check("imem_req", {31'd0, ifc.imem_req}, {31'd0, req_e});
        check("imem_addr", ifc.imem_addr, pc_e);
        fresh = 1'b0;
        if (rv) begin
            pc_e = {rpc[31:2], 2'b00}; hit_e = 1'b0; miss_e = 0;
            if (rpc[1:0] != 2'b00) mis_e = 1'b1;
        end else if (s) begin
        end else if (req_e && h) begin
            sb.push_back({pc_e ^ rmask, pc_e, pc_e + 32'd4});
            pc_e = pc_e + 32'd4; hit_e = 1'b1; miss_e = 0; fresh = 1'b1;
        end else if (req_e) begin
            hit_e = 1'b0;
            if (miss_e < MT) miss_e++;
            if (miss_e == MT) tout_e = 1'b1;
        end
        run_e = 1'b1;
        @(posedge clk); #1;
        check("inst_hit", {31'd0, ifc.inst_hit}, {31'd0, hit_e});
        check("timeout_err", {31'd0, ifc.timeout_err}, {31'd0, tout_e});
        check("misalign_err", {31'd0, ifc.misalign_err}, {31'd0, mis_e});
        if (fresh) begin
            w = sb.pop_front();
            last_word = w;
            check("inst", ifc.inst, w[95:64]);
            check("inst_pc", ifc.inst_pc, w[63:32]);
            check("inst_pc4", ifc.inst_pc4, w[31:0]);
        end else if (hit_e) begin
            check("hold_inst", ifc.inst, last_word[95:64]);
            check("hold_inst_pc", ifc.inst_pc, last_word[63:32]);
        end else begin
            check("bubble", ifc.inst, NOPW);
        end
    endtask

    task automatic start_from_reset();
        rst = 1'b1;
        ifc.imem_hit = 1'b0; ifc.stall = 1'b0; ifc.redirect_valid = 1'b0; ifc.redirect_pc = '0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        check_reset_vals();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rmask = '0;
        start_from_reset();

        // first cycle after reset: no request; then FFFFFFFC wraps to 0,4
        cyc(1'b1, 1'b0, 1'b0, '0);
        for (int unsigned i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        // miss 3 cycles at 0x8, then hit; addr then advances to 0xC
        for (int unsigned i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);

        // redirect to 0x100 under stall, hold a stalled cycle, then fetch
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        // stall with valid inst holds it, hit ignored
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);

        // redirect to 0x40, miss 3, redirect 0x80 mid-miss
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        for (int unsigned i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0080);
        // 3 more misses must not reach the timeout after the restart
        for (int unsigned i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        // 4 consecutive misses raise timeout_err; a stall mid-miss holds count
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);

        // misaligned redirect: sticky flag, aligned address
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0102);
        cyc(1'b1, 1'b0, 1'b0, '0);

        // throughput with distinct data and random stalls
        rmask = 32'hDEAD_0000;
        for (int unsigned i = 0; i < 24; i++)
            cyc(1'b1, ($urandom_range(0, 3) == 0), 1'b0, '0);
        check("sb_drained", sb.size(), 32'd0);

        // asynchronous reset mid-miss clears everything immediately
        rmask = '0;
        cyc(1'b0, 1'b0, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_vals();
        start_from_reset();
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
